// File: rtl/prog_loader.sv
// Byte-serial program loader for the MIPS32 core: packs a big-endian byte
// stream into words, writes them into instruction memory and releases the core.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]  state;
  logic [1:0]  byte_idx;
  logic [23:0] partial;
  logic        last_word;
  logic        accept;

  // s_ready is only ever high in RECV, so an accepted byte implies RECV
  assign accept = s_valid && s_ready;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_idx   <= 2'd0;
      partial    <= 24'd0;
      last_word  <= 1'b0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b1;
      cpu_start  <= 1'b0;
      word_count <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR: begin
          if (load_req) begin
            state      <= ST_RECV;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            err        <= 1'b0;
            word_count <= '0;
            byte_idx   <= 2'd0;
          end
        end

        ST_RECV: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            // overflow or a program ending mid-word both abort without writing
            if ((word_count == CAPACITY) || (s_last && (byte_idx != 2'd3))) begin
              state   <= ST_ERR;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              err     <= 1'b1;
            end else if (byte_idx == 2'd3) begin
              state      <= ST_WRITE;
              s_ready    <= 1'b0;
              imem_we    <= 1'b1;
              imem_addr  <= word_count[ADDR_W-1:0];
              imem_wdata <= {partial, s_data};
              last_word  <= s_last;
            end else begin
              partial <= {partial[15:0], s_data};
            end
          end
        end

        ST_WRITE: begin
          imem_we    <= 1'b0;
          word_count <= word_count + ONE;
          if (last_word) begin
            state     <= ST_DONE;
            cpu_start <= 1'b1;
          end else begin
            state   <= ST_RECV;
            s_ready <= 1'b1;
          end
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          cpu_start <= 1'b0;
          cpu_hold  <= 1'b0;
          busy      <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          s_ready   <= 1'b0;
          imem_we   <= 1'b0;
          cpu_start <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-serial program loader that sits directly upstream of the pipelined MIPS32 core. It assembles an incoming byte stream into 32-bit instruction words, writes them sequentially into the core's instruction memory starting at word address 0, and holds the core off while loading. On a clean end of program it releases the core with a one-cycle start pulse. It replaces direct bench preloading of `instr_mem` / `PC` / `HALTED` with a synthesizable load path.

## Interface
Parameters:
- `ADDR_W`, 10, instruction-memory word-address width; capacity is 2**ADDR_W words

Ports:
- `clk1`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `load_req`  in  1  start a load session; sampled only in IDLE or ERR
- `s_valid`  in  1  byte-stream valid
- `s_data`  in  8  byte-stream data
- `s_last`  in  1  qualifies the final byte of the program
- `s_ready`  out  1  byte accepted when `s_valid && s_ready` at a rising edge
- `imem_we`  out  1  instruction-memory write strobe
- `imem_addr`  out  ADDR_W  word address of the write
- `imem_wdata`  out  32  instruction word
- `cpu_hold`  out  1  core must stay halted while high (drives HALTED/PC-clear logic)
- `cpu_start`  out  1  one-cycle pulse: core sets PC=0, HALTED=0, TAKEN_BRANCH=0
- `word_count`  out  ADDR_W+1  words written in the current or last session
- `busy`  out  1  high in RECV, WRITE, DONE
- `err`  out  1  sticky error for the last session

## Operation
- FSM states: IDLE, RECV, WRITE, DONE, ERR. All outputs registered.
- Reset: state IDLE; `s_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=1, `cpu_start`=0, `word_count`=0, `busy`=0, `err`=0, byte index=0.
- IDLE: `s_ready`=0. `load_req`=1 -> RECV; clear `word_count`, byte index, `err`; set `cpu_hold`=1.
- RECV: `s_ready`=1. Each accepted byte shifts in big-endian: byte 0 -> bits 31:24, byte 3 -> bits 7:0. Byte index increments mod 4.
  - Accepted byte index 3 -> WRITE (remember whether `s_last` was set).
  - Accepted byte with `s_last`=1 and index 0..2 -> ERR; partial word discarded, no write.
  - Accepted byte when `word_count` == 2**ADDR_W -> ERR (overflow); no write.
  - `load_req` ignored.
- WRITE (exactly 1 cycle): `imem_we`=1, `imem_addr`=`word_count`[ADDR_W-1:0], `imem_wdata`=assembled word, `s_ready`=0; `word_count` increments at end of cycle. Next: DONE if the word ended on `s_last`, else RECV.
- DONE (1 cycle): `cpu_start`=1; `cpu_hold` goes 0 for the cycle after, then -> IDLE.
- ERR: `err`=1, `cpu_hold` stays 1, `s_ready`=0. Left only via `load_req` (-> RECV, `err` cleared) or `rst`.
- Loads after a completed session re-assert `cpu_hold` on entry to RECV; prior memory contents beyond the new `word_count` are not cleared.
- Reset mid-session: abandons the session immediately with reset values; words already written stay in memory.

## Timing
- Byte 3 of a word accepted at edge N: `imem_we` high during cycle N..N+1 only (one cycle).
- Throughput: at most 4 bytes per 5 cycles (`s_ready` low during WRITE).
- Final byte at edge N: write cycle after N, `cpu_start` high the following cycle, `cpu_hold` low from the edge after that and stays low until the next `load_req`.
- `cpu_start` never asserts in the same cycle as `imem_we`; never asserts after an error session.
- `s_valid` gaps in RECV are permitted; byte index and partial word are held.

## Test plan
- Load 9 words (36 bytes) 0x2801000a, 0x28020014, 0x28030019, 0x0ce77800, 0x0ce77800, 0x00222000, 0x0ce77800, 0x00832800, 0x00000000 with `s_last` on byte 36 -> memory 0..8 holds them, `word_count`=9, one `cpu_start` pulse, `err`=0, `cpu_hold` 1->0.
- Same stream with random `s_valid` gaps (0-3 cycles) -> identical memory image and count; no byte lost or duplicated.
- 6 bytes with `s_last` on byte 6 -> one write (word 0), `err`=1, `word_count`=1, no `cpu_start`, `cpu_hold`=1.
- `ADDR_W`=2, 5 words streamed -> 4 writes at addresses 0-3, ERR on the first byte of word 5, `word_count`=4.
- `rst` asserted after 10 bytes -> outputs at reset values next cycle, words 0-1 retained; new `load_req` reloads from address 0.
- `load_req` in ERR, then 2-word program -> `err` cleared, `word_count`=2, `cpu_start` pulse.
